dma_axi_mem_slave: RTL and testbench
====================================

Name: dma_axi_mem_slave

Overview:
- AXI4 responder (slave) backed by a flop/SRAM word array; the target end of the DMA master port (axi_req_o/axi_resp_i).
- Serves DMA read and write bursts in block-level and wrapper-level benches, and acts as an on-chip scratchpad in the SoC.
- Read and write channels are fully independent, with one outstanding burst per channel.

Parameters:
- DATA_WIDTH, 512, data bus width in bits; power of 2, ≥32.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 4, AXI ID width.
- DEPTH, 1024, memory depth in DATA_WIDTH words; power of 2.
- BASE_ADDR, 32'h0, byte base address of the memory window.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- awvalid in 1; awready out 1
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- wvalid in 1; wready out 1
- bid/bresp  out  ID_WIDTH/2  write response
- bvalid out 1; bready in 1
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
- arvalid in 1; arready out 1
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data
- rvalid out 1; rready in 1

Behaviour:
- Reset values:
  - All outputs are 0, including awready and arready.
  - awready and arready assert the first cycle after rstn deasserts.
  - Memory contents are not reset.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
- Byte offset within a beat is ignored; the transfer is treated as aligned.
- A burst is legal only if all of the following hold:
  - awburst/arburst == 2'b01 (INCR);
  - size == log2(DATA_WIDTH/8);
  - start and end word lie inside [0, DEPTH).
- Illegal bursts complete all beats with SLVERR (2'b10): no memory update, rdata = 0. Legal bursts return OKAY.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On the AW handshake, latch id, word index, len, and error flag; awready→0; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes bytes where wstrb[i]=1 (if no error), increments the word index and the beat count.
  - On wlast → W_RESP. If wlast beat ≠ beat len+1 (early or late), bresp=SLVERR.
  - Beats beyond len with wlast still low are accepted, counted, and not written.
  - W_RESP: bvalid=1, bid = latched id. On bready → W_IDLE; awready=1 the next cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On the AR handshake, latch id, index, len, error flag; go to R_DATA.
  - First beat: rvalid asserts the cycle after the AR handshake (1-cycle latency). rdata is registered from mem[index].
  - rvalid, rdata, rresp, rlast, rid are held stable while rready=0.
  - On each R handshake the next beat is presented the following cycle, giving 1 beat/cycle at full throughput.
  - rlast=1 on beat len. The handshake of that beat → R_IDLE.
- Simultaneous read and write to the same word in the same cycle: the read beat returns old data; the write commits at that edge.
- AW and AR may handshake in the same cycle. Channels do not interact.
- awlen=0 / arlen=0: single-beat burst, rlast on the first beat.
- Reset mid-burst: both FSMs return to idle immediately; the partial write remains in memory; no response is issued.

Optional Feature:
- Macro: DMA_AXI_SLV_4K_CHECK_EN.
- Defined: a burst whose byte range crosses a 4 KiB boundary is illegal (SLVERR, no write, rdata = 0).
- Undefined: no 4 KiB check; such bursts complete normally if in range.

Test Plan:
- Reset, then AW id=3 addr=BASE+0x40 len=3 with 4 beats wstrb all-ones, data 0xA0..0xA3 → bresp=OKAY, bid=3; AR same addr len=3 → rdata A0..A3, rlast on beat 3, rresp=OKAY, first rvalid 1 cycle after AR handshake.
- Write 1 beat to addr 0x0 with wstrb=64'h1 and data 0xFF over a word preloaded to 0 → read returns 0x...00FF; upper bytes unchanged.
- rready toggled 1,0,0,1 during a len=7 read → no beat lost or duplicated; outputs held stable while stalled; 8 beats total.
- AW addr = BASE + DEPTH*64 - 64 with len=1 (end out of range) → bresp=SLVERR; memory unchanged; matching AR → rresp=SLVERR and rdata=0 on both beats.
- wlast on beat 2 for awlen=3 → bresp=SLVERR; awburst=FIXED → SLVERR; the next legal burst → OKAY.
- With DMA_AXI_SLV_4K_CHECK_EN: AW addr=0xFC0 len=1 → SLVERR; without the macro → OKAY and both words written.

Source files
------------

// File: rtl/dma_axi_mem_slave.sv
// dma_axi_mem_slave: AXI4 INCR memory responder, one outstanding burst per channel.
// Define DMA_AXI_SLV_4K_CHECK_EN to reject bursts that cross a 4 KiB boundary.
module dma_axi_mem_slave #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    parameter int DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam int SZ = $clog2(STRB);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [2:0] SIZE = 3'(SZ);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic R_IDLE = 1'b0, R_DATA = 1'b1;

    function automatic logic legal(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH:0] s, l;
        l = (ADDR_WIDTH+1)'(len);
        s = {1'b0, addr - BASE_ADDR} >> SZ;
`ifdef DMA_AXI_SLV_4K_CHECK_EN
        legal = burst == 2'b01 && size == SIZE && s + l < DEPTH_W
            && (({1'b0, addr} >> SZ) >> (12 - SZ)) == ((({1'b0, addr} >> SZ) + l) >> (12 - SZ));
`else
        legal = burst == 2'b01 && size == SIZE && s + l < DEPTH_W;
`endif
    endfunction

    function automatic logic [AW-1:0] word(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] o;
        o = (addr - BASE_ADDR) >> SZ;
        word = o[AW-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            w_state;
    logic [AW-1:0]         w_idx;
    logic [7:0]            w_len, w_cnt;
    logic                  w_err, w_late, w_fire;
    logic                  r_state;
    logic [AW-1:0]         r_idx;
    logic [7:0]            r_len, r_cnt;
    logic                  r_err;

    assign w_fire = w_state == W_DATA && wvalid;

    // Beats past awlen set w_late and are dropped; the burst still ends on wlast.
    always_ff @(posedge clk) begin
        if (w_fire && !w_err && !w_late)
            for (int i = 0; i < STRB; i++)
                if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= OKAY;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_late  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        bid     <= awid;
                        w_idx   <= word(awaddr);
                        w_len   <= awlen;
                        w_cnt   <= '0;
                        w_err   <= !legal(awaddr, awlen, awsize, awburst);
                        w_late  <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_cnt <= w_cnt + 8'd1;
                        w_idx <= w_idx + 1'b1;
                        if (w_cnt == w_len && !wlast) w_late <= 1'b1;
                        if (wlast) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_err || w_late || w_cnt != w_len) ? SLVERR : OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                default: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // A read racing a write to the same word sees the pre-edge contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= OKAY;
            rlast   <= 1'b0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (r_state == R_IDLE) begin
            arready <= 1'b1;
            if (arvalid && arready) begin
                arready <= 1'b0;
                rvalid  <= 1'b1;
                rid     <= arid;
                r_err   <= !legal(araddr, arlen, arsize, arburst);
                rresp   <= legal(araddr, arlen, arsize, arburst) ? OKAY : SLVERR;
                rdata   <= legal(araddr, arlen, arsize, arburst) ? mem[word(araddr)] : '0;
                rlast   <= arlen == 8'd0;
                r_idx   <= word(araddr) + 1'b1;
                r_len   <= arlen;
                r_cnt   <= 8'd1;
                r_state <= R_DATA;
            end
        end else if (rready) begin
            if (rlast) begin
                rvalid  <= 1'b0;
                rlast   <= 1'b0;
                arready <= 1'b1;
                r_state <= R_IDLE;
            end else begin
                rdata <= r_err ? '0 : mem[r_idx];
                rlast <= r_cnt == r_len;
                r_cnt <= r_cnt + 8'd1;
                r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// tb_dma_axi_mem_slave: directed and random bursts checked against an array memory model.
module tb_dma_axi_mem_slave;
    localparam int DEPTH = 1024;
    localparam logic [31:0] BASE = 32'h0;

    logic         clk = 1'b0, rstn = 1'b0;
    logic [3:0]   awid = '0, arid = '0, bid, rid;
    logic [31:0]  awaddr = '0, araddr = '0;
    logic [7:0]   awlen = '0, arlen = '0;
    logic [2:0]   awsize = '0, arsize = '0;
    logic [1:0]   awburst = '0, arburst = '0, bresp, rresp;
    logic         awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic         bvalid, bready = 1'b0, arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
    logic [511:0] wdata = '0, rdata;
    logic [63:0]  wstrb = '0;

    logic [511:0] ref_mem [DEPTH];
    logic [511:0] beat_data [16];
    logic [63:0]  beat_strb [16];
    int total = 0, bad = 0;

    dma_axi_mem_slave dut (
        .clk(clk), .rstn(rstn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] addr, input int len, input logic [1:0] burst,
                                 input logic [2:0] size);
        longint a = longint'(addr);
        if (burst != 2'b01 || size != 3'd6 || a < longint'(BASE)) return 0;
        if ((a - longint'(BASE)) / 64 + len >= DEPTH) return 0;
`ifdef DMA_AXI_SLV_4K_CHECK_EN
        if (a / 4096 != (a / 64 * 64 + (len + 1) * 64 - 1) / 4096) return 0;
`endif
        return 1;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input int nb);
        bit ok = legal(addr, len, burst, size);
        int n = 0, w;
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 50) begin step(); n++; end
        chk("aw wait", n < 50, 1'b1);
        step();
        awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            wvalid = 1'b1; wdata = beat_data[b]; wstrb = beat_strb[b]; wlast = b == nb - 1;
            n = 0;
            while (!wready && n < 50) begin step(); n++; end
            chk("w wait", n < 50, 1'b1);
            step();
            wvalid = 1'b0; wlast = 1'b0;
            if ($urandom_range(0, 2) == 0) step();
        end
        if (ok) begin
            w = int'((addr - BASE) / 64);
            for (int b = 0; b < nb && b <= len; b++)
                for (int i = 0; i < 64; i++)
                    if (beat_strb[b][i]) ref_mem[w + b][i*8 +: 8] = beat_data[b][i*8 +: 8];
        end
        n = 0;
        while (!bvalid && n < 50) begin step(); n++; end
        chk("b wait", n < 50, 1'b1);
        chk("bid", bid, id);
        chk("bresp", bresp, (ok && nb == len + 1) ? 2'b00 : 2'b10);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid drop", bvalid, 1'b0);
        chk("awready after b", awready, 1'b1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input logic [31:0] pat);
        bit ok = legal(addr, len, burst, size);
        int n = 0, b = 0, cyc = 0, w = int'((addr - BASE) / 64);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 50) begin step(); n++; end
        chk("ar wait", n < 50, 1'b1);
        step();
        arvalid = 1'b0;
        chk("first rvalid latency", rvalid, 1'b1);
        n = 0;
        while (b <= len && n < 400) begin
            n++;
            if (rvalid) begin
                chk("rdata", rdata, ok ? ref_mem[w + b] : 512'd0);
                chk("rresp", rresp, ok ? 2'b00 : 2'b10);
                chk("rid", rid, id);
                chk("rlast", rlast, b == len);
                rready = pat[cyc % 32];
                cyc++;
            end
            step();
            if (rready) b++;
            rready = 1'b0;
        end
        chk("r beats", b, len + 1);
        chk("rvalid end", rvalid, 1'b0);
        chk("arready end", arready, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        int l;
        logic [2:0] sz;
        #2;
        chk("rst awready", awready, 1'b0);
        chk("rst arready", arready, 1'b0);
        chk("rst wready", wready, 1'b0);
        chk("rst bvalid", bvalid, 1'b0);
        chk("rst bid", bid, 4'd0);
        chk("rst bresp", bresp, 2'd0);
        chk("rst rvalid", rvalid, 1'b0);
        chk("rst rdata", rdata, 512'd0);
        chk("rst rresp", rresp, 2'd0);
        chk("rst rlast", rlast, 1'b0);
        chk("rst rid", rid, 4'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("awready after rst", awready, 1'b1);
        chk("arready after rst", arready, 1'b1);

        for (int b = 0; b < 4; b++) begin beat_data[b] = 512'hA0 + 512'(b); beat_strb[b] = '1; end
        do_write(4'd3, BASE + 32'h40, 3, 2'b01, 3'd6, 4);
        do_read(4'd3, BASE + 32'h40, 3, 2'b01, 3'd6, '1);

        beat_data[0] = '0; beat_strb[0] = '1;
        do_write(4'd1, BASE, 0, 2'b01, 3'd6, 1);
        beat_data[0] = rnd512(); beat_data[0][7:0] = 8'hFF; beat_strb[0] = 64'h1;
        do_write(4'd1, BASE, 0, 2'b01, 3'd6, 1);
        chk("byte0 model", ref_mem[0], 512'hFF);
        do_read(4'd2, BASE, 0, 2'b01, 3'd6, '1);

        for (int b = 0; b < 8; b++) begin beat_data[b] = rnd512(); beat_strb[b] = '1; end
        do_write(4'd5, BASE + 32'h400, 7, 2'b01, 3'd6, 8);
        do_read(4'd6, BASE + 32'h400, 7, 2'b01, 3'd6, 32'h99999999);

        beat_data[0] = rnd512(); beat_strb[0] = '1;
        do_write(4'd7, BASE + DEPTH * 64 - 64, 0, 2'b01, 3'd6, 1);
        beat_data[0] = rnd512(); beat_data[1] = rnd512(); beat_strb[1] = '1;
        do_write(4'd8, BASE + DEPTH * 64 - 64, 1, 2'b01, 3'd6, 2);
        do_read(4'd8, BASE + DEPTH * 64 - 64, 1, 2'b01, 3'd6, '1);
        do_read(4'd9, BASE + DEPTH * 64 - 64, 0, 2'b01, 3'd6, '1);

        for (int b = 0; b < 4; b++) begin beat_data[b] = rnd512(); beat_strb[b] = '1; end
        do_write(4'd10, BASE + 32'h800, 3, 2'b01, 3'd6, 2);
        do_write(4'd11, BASE + 32'h900, 0, 2'b00, 3'd6, 1);
        do_write(4'd12, BASE + 32'h900, 1, 2'b01, 3'd6, 2);
        do_read(4'd12, BASE + 32'h900, 1, 2'b01, 3'd6, '1);

        for (int b = 0; b < 2; b++) begin beat_data[b] = rnd512(); beat_strb[b] = '1; end
        do_write(4'd13, 32'hFC0, 1, 2'b01, 3'd6, 2);
        do_read(4'd13, 32'hFC0, 1, 2'b01, 3'd6, $urandom);

        for (int k = 0; k < 6; k++) begin
            a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 64 + 32'($urandom_range(0, 63));
            l = $urandom_range(0, 3);
            sz = ($urandom_range(0, 4) == 0) ? 3'd5 : 3'd6;
            for (int b = 0; b <= l; b++) begin beat_data[b] = rnd512(); beat_strb[b] = '1; end
            do_write(4'($urandom), a, l, 2'b01, sz, l + 1);
            for (int b = 0; b <= l; b++) begin beat_data[b] = rnd512(); beat_strb[b] = {$urandom, $urandom}; end
            do_write(4'($urandom), a, l, 2'b01, sz, l + 1);
            do_read(4'($urandom), a, l, 2'b01, sz, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
